// File: rtl/note_pkg.sv
// Shared sizes and FSM encoding for the note step sequencer.
// Imported by the sequencer top and its note table.
package note_pkg;

    localparam int NUM_STEPS = 32;
    localparam int NOTE_W    = 10;
    localparam int STEP_W    = 5;
    localparam int TICK_W    = 16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PLAY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/note_step_sequencer_table.sv
// Note slot register file: synchronous write, combinational read,
// asynchronous clear. A same-cycle read sees the pre-write value.
module note_table
    import note_pkg::*;
#(
    parameter int NUM_STEPS = note_pkg::NUM_STEPS,
    parameter int NOTE_W    = note_pkg::NOTE_W
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              wr_en_i,
    input  logic [STEP_W-1:0] wr_addr_i,
    input  logic [NOTE_W-1:0] wr_data_i,
    input  logic [STEP_W-1:0] rd_addr_i,
    output logic [NOTE_W-1:0] rd_data_o
);

    logic [NOTE_W-1:0] mem_q [NUM_STEPS];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < NUM_STEPS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_i && (32'(wr_addr_i) < NUM_STEPS)) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_comb begin
        rd_data_o = '0;
        if (32'(rd_addr_i) < NUM_STEPS) begin
            rd_data_o = mem_q[rd_addr_i];
        end
    end

endmodule

// File: rtl/note_step_sequencer.sv
// Step sequencer: plays table slots 0..len, each held tick_div+1 clocks,
// optionally looping, with a one-cycle done pulse at the end of a pass.
module note_step_sequencer
    import note_pkg::*;
#(
    parameter int NUM_STEPS = note_pkg::NUM_STEPS,
    parameter int NOTE_W    = note_pkg::NOTE_W
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              start_in,
    input  logic              stop_in,
    input  logic              loop_in,
    input  logic [STEP_W-1:0] len_in,
    input  logic [TICK_W-1:0] tick_div_in,
    input  logic              wr_en_in,
    input  logic [STEP_W-1:0] wr_addr_in,
    input  logic [NOTE_W-1:0] wr_data_in,
    output logic [NOTE_W-1:0] note_out,
    output logic              note_valid_out,
    output logic [STEP_W-1:0] step_out,
    output logic              busy_out,
    output logic              done_out
);

    logic [1:0]        state_q, state_d;
    logic [STEP_W-1:0] len_q, len_d;
    logic [TICK_W-1:0] div_q, div_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [NOTE_W-1:0] note_q, note_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              last_step;
    logic [STEP_W-1:0] rd_addr;
    logic [NOTE_W-1:0] rd_data;

    assign last_step = (step_q == len_q);

    // Fetch address is the slot loaded on the next step boundary.
    assign rd_addr = (state_q == ST_PLAY && !last_step)
                   ? step_q + STEP_W'(1) : '0;

    note_table #(
        .NUM_STEPS (NUM_STEPS),
        .NOTE_W    (NOTE_W)
    ) u_table (
        .clk_i     (clk_in),
        .rst_n_i   (rst_n_in),
        .wr_en_i   (wr_en_in),
        .wr_addr_i (wr_addr_in),
        .wr_data_i (wr_data_in),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data)
    );

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        div_d   = div_q;
        tick_d  = tick_q;
        step_d  = step_q;
        note_d  = note_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_in && !stop_in) begin
                    state_d = ST_PLAY;
                    len_d   = len_in;
                    div_d   = tick_div_in;
                    tick_d  = '0;
                    step_d  = '0;
                    note_d  = rd_data;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            ST_PLAY: begin
                if (stop_in) begin
                    state_d = ST_IDLE;
                    tick_d  = '0;
                    step_d  = '0;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                end else if (tick_q != div_q) begin
                    tick_d = tick_q + TICK_W'(1);
                end else begin
                    tick_d = '0;
                    if (!last_step || loop_in) begin
                        step_d = last_step ? '0 : step_q + STEP_W'(1);
                        note_d = rd_data;
                    end else begin
                        state_d = ST_DONE;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            div_q   <= '0;
            tick_q  <= '0;
            step_q  <= '0;
            note_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            div_q   <= div_d;
            tick_q  <= tick_d;
            step_q  <= step_d;
            note_q  <= note_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign note_out       = note_q;
    assign note_valid_out = valid_q;
    assign step_out       = step_q;
    assign busy_out       = busy_q;
    assign done_out       = done_q;

endmodule

// File: tb/tb_note_step_sequencer.sv
// Directed self-checking bench for note_step_sequencer.
module tb_note_step_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, stop, loop_en;
    logic [4:0]  len;
    logic [15:0] div;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [9:0]  wr_data;
    logic [9:0]  note;
    logic        valid;
    logic [4:0]  step;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    note_step_sequencer dut (
        .clk_in         (clk),
        .rst_n_in       (rst_n),
        .start_in       (start),
        .stop_in        (stop),
        .loop_in        (loop_en),
        .len_in         (len),
        .tick_div_in    (div),
        .wr_en_in       (wr_en),
        .wr_addr_in     (wr_addr),
        .wr_data_in     (wr_data),
        .note_out       (note),
        .note_valid_out (valid),
        .step_out       (step),
        .busy_out       (busy),
        .done_out       (done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic kick(input logic [4:0] l, input logic [15:0] d,
                        input logic lp);
        len     = l;
        div     = d;
        loop_en = lp;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({note, valid, step, busy, done} !== 18'h0) begin
            errors++;
            $display("FAIL reset_outs: got %h expected 0",
                     {note, valid, step, busy, done});
        end
        rst_n = 1'b1;
        repeat (3) tick();
        checks++;
        if (busy !== 1'b0 || valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_autostart: busy %b valid %b expected 0 0",
                     busy, valid);
        end
    endtask

    task automatic load_table();
        for (int i = 0; i < 32; i++) begin
            wr_en   = 1'b1;
            wr_addr = 5'(i);
            wr_data = 10'(i + 100);
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic test_single_pass();
        kick(5'd3, 16'd1, 1'b0);
        for (int c = 0; c < 8; c++) begin
            checks++;
            if (note !== 10'(100 + c / 2) || step !== 5'(c / 2) ||
                valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL pass_c%0d: note %0d step %0d v%b b%b d%b expected note %0d step %0d v1 b1 d0",
                         c, note, step, valid, busy, done, 100 + c / 2, c / 2);
            end
            tick();
        end
        checks++;
        if (done !== 1'b1 || valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL pass_done: d%b v%b b%b expected d1 v0 b0",
                     done, valid, busy);
        end
        checks++;
        if (note !== 10'd103) begin
            errors++;
            $display("FAIL pass_note_hold: got %0d expected 103", note);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL pass_after: d%b b%b expected d0 b0", done, busy);
        end
    endtask

    task automatic test_loop();
        kick(5'd1, 16'd0, 1'b1);
        for (int c = 0; c < 6; c++) begin
            checks++;
            if (step !== 5'(c % 2) || valid !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL loop_c%0d: step %0d v%b d%b expected step %0d v1 d0",
                         c, step, valid, done, c % 2);
            end
            if (c == 5) loop_en = 1'b0;
            tick();
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL loop_done: d%b b%b expected d1 b0", done, busy);
        end
        tick();
    endtask

    task automatic test_stop();
        bit seen = 1'b0;
        kick(5'd31, 16'd1, 1'b0);
        repeat (4) tick();
        checks++;
        if (step !== 5'd2 || note !== 10'd102) begin
            errors++;
            $display("FAIL stop_pre: step %0d note %0d expected 2 102", step, note);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++;
        if (busy !== 1'b0 || valid !== 1'b0 || step !== 5'd0 ||
            done !== 1'b0 || note !== 10'd102) begin
            errors++;
            $display("FAIL stop_post: b%b v%b step %0d d%b note %0d expected b0 v0 step 0 d0 note 102",
                     busy, valid, step, done, note);
        end
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL stop_quiet: got activity %b expected 0", seen);
        end
    endtask

    task automatic test_live_write();
        kick(5'd1, 16'd3, 1'b0);
        wr_en   = 1'b1;
        wr_addr = 5'd1;
        wr_data = 10'h3FF;
        tick();
        wr_en = 1'b0;
        repeat (3) tick();
        checks++;
        if (step !== 5'd1 || note !== 10'h3FF) begin
            errors++;
            $display("FAIL wr_new: step %0d note %h expected 1 3ff", step, note);
        end
        repeat (4) tick();
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL wr_done1: got %b expected 1", done);
        end
        tick();
        kick(5'd1, 16'd3, 1'b0);
        repeat (3) tick();
        wr_en   = 1'b1;
        wr_addr = 5'd1;
        wr_data = 10'h055;
        tick();
        wr_en = 1'b0;
        checks++;
        if (step !== 5'd1 || note !== 10'h3FF) begin
            errors++;
            $display("FAIL wr_rbw: step %0d note %h expected 1 3ff", step, note);
        end
        repeat (5) tick();
        kick(5'd1, 16'd3, 1'b0);
        repeat (4) tick();
        checks++;
        if (note !== 10'h055) begin
            errors++;
            $display("FAIL wr_later: note %h expected 055", note);
        end
        repeat (5) tick();
    endtask

    task automatic test_start_stop();
        start = 1'b1;
        stop  = 1'b1;
        len   = 5'd3;
        div   = 16'd0;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        checks++;
        if (busy !== 1'b0 || valid !== 1'b0) begin
            errors++;
            $display("FAIL both_high: b%b v%b expected 0 0", busy, valid);
        end
        kick(5'd3, 16'd0, 1'b0);
        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        checks++;
        if (step !== 5'd2 || busy !== 1'b1) begin
            errors++;
            $display("FAIL no_restart: step %0d b%b expected 2 1", step, busy);
        end
        tick();
        tick();
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL restart_done: got %b expected 1", done);
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL restart_idle: busy %b expected 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        kick(5'd31, 16'd2, 1'b0);
        repeat (7) tick();
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({note, valid, step, busy, done} !== 18'h0) begin
            errors++;
            $display("FAIL async_reset: got %h expected 0",
                     {note, valid, step, busy, done});
        end
        #2;
        rst_n = 1'b1;
        repeat (3) tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_needs_start: busy %b expected 0", busy);
        end
        kick(5'd3, 16'd0, 1'b0);
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (note !== 10'd0 || valid !== 1'b1 || step !== 5'(c)) begin
                errors++;
                $display("FAIL cleared_c%0d: note %0d v%b step %0d expected 0 1 %0d",
                         c, note, valid, step, c);
            end
            tick();
        end
        tick();
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        stop    = 1'b0;
        loop_en = 1'b0;
        len     = '0;
        div     = '0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        test_reset();
        load_table();
        test_single_pass();
        test_loop();
        test_stop();
        test_live_write();
        test_start_stop();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
